// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for the 16-bit bus
// microcontroller. It owns the instruction register and produces every
// latch, enable and tri-state control for the datapath.
//
// Optional feature: define CU_MFC_TIMEOUT_EN to add an MFC watchdog. The
// memory wait states F1, L1 and S2 then give up after MFC_TIMEOUT cycles
// without MFC and park in FAULT until reset. Without the macro the sequencer
// waits for MFC indefinitely, and fault is constant 0.
module control_unit #(
  parameter int WIDTH = 16,
  parameter int MFC_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] busIn,
  input  logic             MFC,
  output logic             PCOutEn,
  output logic             PCInc,
  output logic             MARin,
  output logic             memEN,
  output logic             memRW,
  output logic             MDRwriteEN,
  output logic             MDRreadEN,
  output logic             MDRout,
  output logic             r0Latch,
  output logic             r1Latch,
  output logic             r2Latch,
  output logic             r3Latch,
  output logic             r0Out,
  output logic             r1Out,
  output logic             r2Out,
  output logic             r3Out,
  output logic             ALUin0,
  output logic             ALUin1,
  output logic             ALUOutLatch,
  output logic             ALUOutEn,
  output logic [2:0]       opControl,
  output logic             p0Latch,
  output logic             p1Out,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [4:0] {
    IDLE, F0, F1, F2, DEC,
    M0,
    L0, L1, L2,
    S0, S1, S2,
    A0, A1, A2, A3,
    I0, O0,
    HALT, FAULT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ALU = 4'h4;
  localparam logic [3:0] OP_IN  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state, next_state;
  logic [WIDTH-1:0] ir;
  logic [3:0] opcode;
  logic [1:0] rd, rs;
  logic [3:0] r_latch, r_out;
  logic timeout_hit;
  logic unused_ir;

  assign opcode = ir[15:12];
  assign rd = ir[11:10];
  assign rs = ir[9:8];

  // The upper, reserved and operand-free bits of IR are kept so the register
  // matches the bus width; only the decoded fields drive logic.
  assign unused_ir = ^ir;

  // State register and instruction register; IR captures the bus at the end of F2.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ir <= '0;
    end else begin
      state <= next_state;
      if (state == F2) begin
        ir <= busIn;
      end
    end
  end

`ifdef CU_MFC_TIMEOUT_EN
  // The counter only ever holds 0..MFC_TIMEOUT-1, since the last value forces an exit.
  localparam int CNT_W = (MFC_TIMEOUT > 1) ? $clog2(MFC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic in_wait;

  assign in_wait = (state == F1) || (state == L1) || (state == S2);
  assign timeout_hit = in_wait && !MFC && (wait_cnt == CNT_LAST);

  // Wait counter: restarts whenever the state changes, advances on each cycle spent waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != next_state) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic: fetch, dispatch on the opcode, per-instruction micro-steps.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = F0;
      F0:   next_state = F1;
      F1: begin
        if (MFC) begin
          next_state = F2;
        end else if (timeout_hit) begin
          next_state = FAULT;
        end
      end
      F2:   next_state = DEC;
      DEC: begin
        case (opcode)
          OP_NOP:  next_state = F0;
          OP_MOV:  next_state = M0;
          OP_LD:   next_state = L0;
          OP_ST:   next_state = S0;
          OP_ALU:  next_state = A0;
          OP_IN:   next_state = I0;
          OP_OUT:  next_state = O0;
          OP_HLT:  next_state = HALT;
          default: next_state = F0;
        endcase
      end
      M0:   next_state = F0;
      L0:   next_state = L1;
      L1: begin
        if (MFC) begin
          next_state = L2;
        end else if (timeout_hit) begin
          next_state = FAULT;
        end
      end
      L2:   next_state = F0;
      S0:   next_state = S1;
      S1:   next_state = S2;
      S2: begin
        if (MFC) begin
          next_state = F0;
        end else if (timeout_hit) begin
          next_state = FAULT;
        end
      end
      A0:   next_state = A1;
      A1:   next_state = A2;
      A2:   next_state = A3;
      A3:   next_state = F0;
      I0:   next_state = F0;
      O0:   next_state = F0;
      HALT: next_state = HALT;
      FAULT: next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: each state enables exactly the controls of its micro-step.
  always_comb begin
    PCOutEn = 1'b0;
    PCInc = 1'b0;
    MARin = 1'b0;
    memEN = 1'b0;
    memRW = 1'b0;
    MDRwriteEN = 1'b0;
    MDRreadEN = 1'b0;
    MDRout = 1'b0;
    r_latch = '0;
    r_out = '0;
    ALUin0 = 1'b0;
    ALUin1 = 1'b0;
    ALUOutLatch = 1'b0;
    ALUOutEn = 1'b0;
    p0Latch = 1'b0;
    p1Out = 1'b0;
    halted = 1'b0;
    fault = 1'b0;
    opControl = ir[2:0];
    case (state)
      IDLE: opControl = 3'b000;
      F0: begin
        PCOutEn = 1'b1;
        MARin = 1'b1;
      end
      F1: begin
        memEN = 1'b1;
        memRW = 1'b1;
        MDRreadEN = MFC;
      end
      F2: begin
        MDRout = 1'b1;
        PCInc = 1'b1;
      end
      M0: begin
        r_out[rs] = 1'b1;
        r_latch[rd] = 1'b1;
      end
      L0: begin
        r_out[rs] = 1'b1;
        MARin = 1'b1;
      end
      L1: begin
        memEN = 1'b1;
        memRW = 1'b1;
        MDRreadEN = MFC;
      end
      L2: begin
        MDRout = 1'b1;
        r_latch[rd] = 1'b1;
      end
      S0: begin
        r_out[rd] = 1'b1;
        MARin = 1'b1;
      end
      S1: begin
        r_out[rs] = 1'b1;
        MDRwriteEN = 1'b1;
      end
      S2: begin
        memEN = 1'b1;
        memRW = 1'b0;
      end
      A0: begin
        r_out[rd] = 1'b1;
        ALUin0 = 1'b1;
      end
      A1: begin
        r_out[rs] = 1'b1;
        ALUin1 = 1'b1;
      end
      A2: ALUOutLatch = 1'b1;
      A3: begin
        ALUOutEn = 1'b1;
        r_latch[rd] = 1'b1;
      end
      I0: begin
        p1Out = 1'b1;
        r_latch[rd] = 1'b1;
      end
      O0: begin
        r_out[rs] = 1'b1;
        p0Latch = 1'b1;
      end
      HALT: halted = 1'b1;
      FAULT: begin
        fault = 1'b1;
        opControl = 3'b000;
      end
      default: ;
    endcase
  end

  assign r0Latch = r_latch[0];
  assign r1Latch = r_latch[1];
  assign r2Latch = r_latch[2];
  assign r3Latch = r_latch[3];
  assign r0Out = r_out[0];
  assign r1Out = r_out[1];
  assign r2Out = r_out[2];
  assign r3Out = r_out[3];

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives control_unit with directed and random instruction
// streams and compares every cycle's control outputs against a per-instruction
// micro-step plan built from the instruction set's behaviour.
module tb_control_unit;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic [WIDTH-1:0] busIn;
  logic MFC;
  logic PCOutEn, PCInc, MARin, memEN, memRW, MDRwriteEN, MDRreadEN, MDRout;
  logic r0Latch, r1Latch, r2Latch, r3Latch, r0Out, r1Out, r2Out, r3Out;
  logic ALUin0, ALUin1, ALUOutLatch, ALUOutEn;
  logic [2:0] opControl;
  logic p0Latch, p1Out, halted, fault;

  always #5 clk = ~clk;

  control_unit #(.WIDTH(WIDTH), .MFC_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .busIn(busIn), .MFC(MFC),
    .PCOutEn(PCOutEn), .PCInc(PCInc), .MARin(MARin),
    .memEN(memEN), .memRW(memRW),
    .MDRwriteEN(MDRwriteEN), .MDRreadEN(MDRreadEN), .MDRout(MDRout),
    .r0Latch(r0Latch), .r1Latch(r1Latch), .r2Latch(r2Latch), .r3Latch(r3Latch),
    .r0Out(r0Out), .r1Out(r1Out), .r2Out(r2Out), .r3Out(r3Out),
    .ALUin0(ALUin0), .ALUin1(ALUin1), .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn),
    .opControl(opControl), .p0Latch(p0Latch), .p1Out(p1Out),
    .halted(halted), .fault(fault)
  );

  // Observed outputs, packed as {opControl, 24 control bits}.
  logic [26:0] obs;
  assign obs = {opControl, fault, halted, p1Out, p0Latch,
                ALUOutEn, ALUOutLatch, ALUin1, ALUin0,
                r3Out, r2Out, r1Out, r0Out,
                r3Latch, r2Latch, r1Latch, r0Latch,
                MDRout, MDRreadEN, MDRwriteEN, memRW, memEN, MARin, PCInc, PCOutEn};

  localparam logic [23:0] C_PCOUT  = 24'd1 << 0;
  localparam logic [23:0] C_PCINC  = 24'd1 << 1;
  localparam logic [23:0] C_MARIN  = 24'd1 << 2;
  localparam logic [23:0] C_MEMEN  = 24'd1 << 3;
  localparam logic [23:0] C_MEMRW  = 24'd1 << 4;
  localparam logic [23:0] C_MDRWR  = 24'd1 << 5;
  localparam logic [23:0] C_MDRRD  = 24'd1 << 6;
  localparam logic [23:0] C_MDROUT = 24'd1 << 7;
  localparam logic [23:0] C_ALUIN0 = 24'd1 << 16;
  localparam logic [23:0] C_ALUIN1 = 24'd1 << 17;
  localparam logic [23:0] C_ALULAT = 24'd1 << 18;
  localparam logic [23:0] C_ALUOUT = 24'd1 << 19;
  localparam logic [23:0] C_P0LAT  = 24'd1 << 20;
  localparam logic [23:0] C_P1OUT  = 24'd1 << 21;
  localparam logic [23:0] C_HALTED = 24'd1 << 22;
  localparam logic [23:0] C_FAULT  = 24'd1 << 23;

  localparam int MFC_LO = 0;
  localparam int MFC_HI = 1;
  localparam int MFC_ANY = 2;

  function automatic logic [23:0] rLatch(input logic [1:0] r);
    return 24'd1 << (8 + int'(r));
  endfunction

  function automatic logic [23:0] rOut(input logic [1:0] r);
    return 24'd1 << (12 + int'(r));
  endfunction

  typedef struct {
    logic [23:0] name;
    logic [26:0] exp;
    int mfcMode;
    logic [15:0] bus;
    bit busFixed;
    bit rstHere;
  } step_t;

  step_t plan[$];
  logic [15:0] modelIr;
  int passCount = 0;
  int totalCount = 0;

  task automatic addStep(input logic [23:0] name, input logic [23:0] ctl, input logic [2:0] opc,
                         input int mfcMode, input logic [15:0] bus, input bit busFixed);
    step_t s;
    s.name = name;
    s.exp = {opc, ctl};
    s.mfcMode = mfcMode;
    s.bus = bus;
    s.busFixed = busFixed;
    s.rstHere = 1'b0;
    plan.push_back(s);
  endtask

  // Reference model: expand one instruction into its expected cycle-by-cycle controls.
  task automatic applyStimulus(input logic [15:0] instr, input int waitF, input int waitM);
    logic [2:0] oldOp;
    logic [2:0] newOp;
    logic [1:0] rd;
    logic [1:0] rs;
    oldOp = modelIr[2:0];
    newOp = instr[2:0];
    rd = instr[11:10];
    rs = instr[9:8];
    addStep("F0", C_PCOUT | C_MARIN, oldOp, MFC_ANY, 16'h0, 1'b0);
    for (int i = 0; i < waitF; i++) addStep("F1w", C_MEMEN | C_MEMRW, oldOp, MFC_LO, 16'h0, 1'b0);
    addStep("F1", C_MEMEN | C_MEMRW | C_MDRRD, oldOp, MFC_HI, 16'h0, 1'b0);
    addStep("F2", C_MDROUT | C_PCINC, oldOp, MFC_ANY, instr, 1'b1);
    modelIr = instr;
    addStep("DEC", 24'd0, newOp, MFC_ANY, 16'h0, 1'b0);
    case (instr[15:12])
      4'h1: addStep("M0", rOut(rs) | rLatch(rd), newOp, MFC_ANY, 16'h0, 1'b0);
      4'h2: begin
        addStep("L0", rOut(rs) | C_MARIN, newOp, MFC_ANY, 16'h0, 1'b0);
        for (int i = 0; i < waitM; i++) addStep("L1w", C_MEMEN | C_MEMRW, newOp, MFC_LO, 16'h0, 1'b0);
        addStep("L1", C_MEMEN | C_MEMRW | C_MDRRD, newOp, MFC_HI, 16'h0, 1'b0);
        addStep("L2", C_MDROUT | rLatch(rd), newOp, MFC_ANY, 16'h0, 1'b0);
      end
      4'h3: begin
        addStep("S0", rOut(rd) | C_MARIN, newOp, MFC_ANY, 16'h0, 1'b0);
        addStep("S1", rOut(rs) | C_MDRWR, newOp, MFC_ANY, 16'h0, 1'b0);
        for (int i = 0; i < waitM; i++) addStep("S2w", C_MEMEN, newOp, MFC_LO, 16'h0, 1'b0);
        addStep("S2", C_MEMEN, newOp, MFC_HI, 16'h0, 1'b0);
      end
      4'h4: begin
        addStep("A0", rOut(rd) | C_ALUIN0, newOp, MFC_ANY, 16'h0, 1'b0);
        addStep("A1", rOut(rs) | C_ALUIN1, newOp, MFC_ANY, 16'h0, 1'b0);
        addStep("A2", C_ALULAT, newOp, MFC_ANY, 16'h0, 1'b0);
        addStep("A3", C_ALUOUT | rLatch(rd), newOp, MFC_ANY, 16'h0, 1'b0);
      end
      4'h5: addStep("I0", C_P1OUT | rLatch(rd), newOp, MFC_ANY, 16'h0, 1'b0);
      4'h6: addStep("O0", rOut(rs) | C_P0LAT, newOp, MFC_ANY, 16'h0, 1'b0);
      4'hF: for (int i = 0; i < 20; i++) addStep("HLT", C_HALTED, newOp, MFC_ANY, 16'h0, 1'b0);
      default: ;
    endcase
  endtask

  // Compare all outputs, and confirm no more than one bus driver is active.
  task automatic checkOutput(input logic [23:0] name, input logic [26:0] exp);
    int drivers;
    drivers = $countones({ALUOutEn, PCOutEn, r0Out, r1Out, r2Out, r3Out, MDRout, p1Out});
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s outputs observed=%h expected=%h", name, obs, exp);
    totalCount++;
    assert (drivers <= 1) passCount++;
    else $error("[TB] FAIL %s busDrivers observed=%0d expected<=1", name, drivers);
  endtask

  // Play the plan one cycle per step; a step flagged rstHere resets the DUT.
  task automatic runPlan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      case (s.mfcMode)
        MFC_LO: MFC = 1'b0;
        MFC_HI: MFC = 1'b1;
        default: MFC = 1'($urandom_range(0, 1));
      endcase
      busIn = s.busFixed ? s.bus : 16'($urandom);
      rst = s.rstHere;
      #1;
      checkOutput(s.name, s.exp);
      if (s.rstHere) begin
        plan.delete();
        modelIr = 16'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        MFC = 1'($urandom_range(0, 1));
        #1;
        checkOutput("IDL", 27'd0);
      end
    end
  endtask

  initial begin
    logic [15:0] instr;
    rst = 1'b1;
    MFC = 1'b0;
    busIn = 16'h0;
    modelIr = 16'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("RST", 27'd0);

    applyStimulus(16'h1600, 0, 0);
    runPlan();
    applyStimulus(16'h4106, 0, 0);
    runPlan();
    applyStimulus(16'h3900, 0, 3);
    runPlan();
    applyStimulus(16'h2E07, 2, 1);
    runPlan();
    applyStimulus(16'h4F03, 1, 0);
    runPlan();

    for (int n = 0; n < 40; n++) begin
      instr = 16'($urandom);
      instr[15:12] = 4'($urandom_range(0, 14));
      applyStimulus(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      runPlan();
    end

    applyStimulus(16'hF000, 0, 0);
    plan[plan.size() - 1].rstHere = 1'b1;
    runPlan();

    applyStimulus(16'h2600, 0, 0);
    for (int i = 0; i < plan.size(); i++) begin
      if (plan[i].name == "L1") begin
        plan[i].rstHere = 1'b1;
        break;
      end
    end
    runPlan();

    applyStimulus(16'h0000, 0, 0);
    runPlan();

`ifdef CU_MFC_TIMEOUT_EN
    applyStimulus(16'h0005, 3, 0);
    runPlan();
    applyStimulus(16'h2603, 3, 3);
    runPlan();
    applyStimulus(16'h3902, 0, 3);
    runPlan();
    addStep("F0", C_PCOUT | C_MARIN, modelIr[2:0], MFC_ANY, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) addStep("F1w", C_MEMEN | C_MEMRW, modelIr[2:0], MFC_LO, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) addStep("FLT", C_FAULT, 3'b000, MFC_ANY, 16'h0, 1'b0);
    plan[plan.size() - 1].rstHere = 1'b1;
    runPlan();
`else
    applyStimulus(16'h0001, 300, 0);
    runPlan();
`endif

    applyStimulus(16'h5C00, 0, 0);
    runPlan();

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
